// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: serial front end for the 8-bit ALU.
// Collects operand A, operand B and opcode bytes from the UART receiver,
// registers them toward the ALU, waits one settle cycle, captures the result
// and hands it to the UART transmitter with a start/done handshake.
// Optional build macro ALU_SEQ_CARRY_BYTE_EN: also transmit the latched carry
// as a second byte after the result byte.
module alu_uart_sequencer #(
    parameter int unsigned BUS_SIZE    = 8,
    parameter int unsigned OPCODE_SIZE = 6
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic [BUS_SIZE-1:0]    i_rx_data,
    input  logic                   i_rx_done,
    input  logic [BUS_SIZE-1:0]    i_alu_result,
    input  logic                   i_alu_carry,
    input  logic                   i_tx_done,
    output logic [BUS_SIZE-1:0]    o_datoA,
    output logic [BUS_SIZE-1:0]    o_datoB,
    output logic [OPCODE_SIZE-1:0] o_opcode,
    output logic [BUS_SIZE-1:0]    o_tx_data,
    output logic                   o_tx_start,
    output logic                   o_busy
);

    typedef enum logic [2:0] {
        StRxA,
        StRxB,
        StRxOp,
        StExec,
        StSend,
        StWaitTx
`ifdef ALU_SEQ_CARRY_BYTE_EN
        ,
        StSendC,
        StWaitTxC
`endif
    } state_e;

    state_e                 state_q, state_d;
    logic [BUS_SIZE-1:0]    dato_a_q, dato_a_d;
    logic [BUS_SIZE-1:0]    dato_b_q, dato_b_d;
    logic [OPCODE_SIZE-1:0] opcode_q, opcode_d;
    logic [BUS_SIZE-1:0]    tx_data_q, tx_data_d;
    logic                   carry_q, carry_d;

    // Next-state and register-load decode; bytes arriving while busy fall through untouched.
    always_comb begin
        state_d   = state_q;
        dato_a_d  = dato_a_q;
        dato_b_d  = dato_b_q;
        opcode_d  = opcode_q;
        tx_data_d = tx_data_q;
        carry_d   = carry_q;
        unique case (state_q)
            StRxA: begin
                if (i_rx_done) begin
                    dato_a_d = i_rx_data;
                    state_d  = StRxB;
                end
            end
            StRxB: begin
                if (i_rx_done) begin
                    dato_b_d = i_rx_data;
                    state_d  = StRxOp;
                end
            end
            StRxOp: begin
                if (i_rx_done) begin
                    // Upper bits of the opcode byte are discarded.
                    opcode_d = i_rx_data[OPCODE_SIZE-1:0];
                    state_d  = StExec;
                end
            end
            StExec: begin
                // Operands have been stable for a full cycle: capture the ALU now.
                tx_data_d = i_alu_result;
                carry_d   = i_alu_carry;
                state_d   = StSend;
            end
            StSend: begin
                state_d = StWaitTx;
            end
            StWaitTx: begin
                if (i_tx_done) begin
`ifdef ALU_SEQ_CARRY_BYTE_EN
                    // Carry byte must already be on o_tx_data when its start pulse fires.
                    tx_data_d = {{(BUS_SIZE-1){1'b0}}, carry_q};
                    state_d   = StSendC;
`else
                    state_d   = StRxA;
`endif
                end
            end
`ifdef ALU_SEQ_CARRY_BYTE_EN
            StSendC: begin
                state_d = StWaitTxC;
            end
            StWaitTxC: begin
                if (i_tx_done) begin
                    state_d = StRxA;
                end
            end
`endif
            default: begin
                state_d = StRxA;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset aborts any transaction.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= StRxA;
            dato_a_q  <= '0;
            dato_b_q  <= '0;
            opcode_q  <= '0;
            tx_data_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dato_a_q  <= dato_a_d;
            dato_b_q  <= dato_b_d;
            opcode_q  <= opcode_d;
            tx_data_q <= tx_data_d;
            carry_q   <= carry_d;
        end
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        o_tx_start = 1'b0;
        o_busy     = 1'b1;
        unique case (state_q)
            StRxA, StRxB, StRxOp: o_busy = 1'b0;
            StSend:               o_tx_start = 1'b1;
`ifdef ALU_SEQ_CARRY_BYTE_EN
            StSendC:              o_tx_start = 1'b1;
`endif
            default:              o_busy = 1'b1;
        endcase
    end

`ifndef ALU_SEQ_CARRY_BYTE_EN
    // Carry is latched but never transmitted in this build.
    logic unused_carry;
    assign unused_carry = carry_q;
`endif

    assign o_datoA   = dato_a_q;
    assign o_datoB   = dato_b_q;
    assign o_opcode  = opcode_q;
    assign o_tx_data = tx_data_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed testbench for alu_uart_sequencer with a small behavioural ALU peer.
// Honours ALU_SEQ_CARRY_BYTE_EN to expect the extra carry byte.
module tb_alu_uart_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       tx_done;
    logic [7:0] dato_a;
    logic [7:0] dato_b;
    logic [5:0] opcode;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;

    alu_uart_sequencer #(
        .BUS_SIZE    (8),
        .OPCODE_SIZE (6)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_alu_result (alu_result),
        .i_alu_carry  (alu_carry),
        .i_tx_done    (tx_done),
        .o_datoA      (dato_a),
        .o_datoB      (dato_b),
        .o_opcode     (opcode),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU peer: ADD 20, SUB 22, AND 24, OR 25, XOR 26, NOR 27, SRL 02, SRA 03 (shift by one),
    // anything else behaves as ADD.
    logic [8:0] alu_wide;
    always_comb begin
        alu_wide = 9'd0;
        case (opcode)
            6'h20:   alu_wide = {1'b0, dato_a} + {1'b0, dato_b};
            6'h22:   alu_wide = {1'b0, dato_a} - {1'b0, dato_b};
            6'h24:   alu_wide = {1'b0, dato_a & dato_b};
            6'h25:   alu_wide = {1'b0, dato_a | dato_b};
            6'h26:   alu_wide = {1'b0, dato_a ^ dato_b};
            6'h27:   alu_wide = {1'b0, ~(dato_a | dato_b)};
            6'h02:   alu_wide = {1'b0, 1'b0, dato_a[7:1]};
            6'h03:   alu_wide = {1'b0, dato_a[7], dato_a[7:1]};
            default: alu_wide = {1'b0, dato_a} + {1'b0, dato_b};
        endcase
    end
    assign alu_result = alu_wide[7:0];
    assign alu_carry  = alu_wide[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All drivers change #1 after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic pulse_tx_done(input logic with_rx);
        tx_done = 1'b1;
        if (with_rx) begin
            rx_data = 8'hAA;
            rx_done = 1'b1;
        end
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic do_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] exp_res,
                          input logic exp_carry, input logic inject);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        check({tag, "_exec_busy"}, busy, 1);
        check({tag, "_exec_start"}, tx_start, 0);
        check({tag, "_opcode"}, opcode, op[5:0]);
        @(posedge clk);
        #1;
        check({tag, "_start"}, tx_start, 1);
        check({tag, "_data"}, tx_data, exp_res);
        @(posedge clk);
        #1;
        check({tag, "_start_once"}, tx_start, 0);
        check({tag, "_hold"}, tx_data, exp_res);
        check({tag, "_wait_busy"}, busy, 1);
        if (inject) begin
            send_byte(8'hAA);
            check({tag, "_drop_a"}, dato_a, a);
            check({tag, "_drop_busy"}, busy, 1);
        end
`ifdef ALU_SEQ_CARRY_BYTE_EN
        pulse_tx_done(1'b0);
        check({tag, "_c_start"}, tx_start, 1);
        check({tag, "_c_data"}, tx_data, {7'd0, exp_carry});
        @(posedge clk);
        #1;
        check({tag, "_c_busy"}, busy, 1);
        pulse_tx_done(inject);
`else
        n_checks++;
        assert (exp_carry === alu_carry || 1'b1);
        pulse_tx_done(inject);
`endif
        check({tag, "_idle"}, busy, 0);
        check({tag, "_keep_a"}, dato_a, a);
        check({tag, "_keep_b"}, dato_b, b);
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a", dato_a, 0);
        check("rst_b", dato_b, 0);
        check("rst_op", opcode, 0);
        check("rst_txd", tx_data, 0);
        check("rst_start", tx_start, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stray tx_done while idle is ignored.
        pulse_tx_done(1'b0);
        check("stray_txdone_busy", busy, 0);
        check("stray_txdone_start", tx_start, 0);

        // Reset mid-stream, asserted between edges.
        send_byte(8'h05);
        check("mid_a", dato_a, 8'h05);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_a", dato_a, 0);
        check("mid_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_txn("after_rst", 8'h03, 8'h04, 8'h20, 8'h07, 1'b0, 1'b0);

        // Reset during EXEC aborts: nothing is sent afterwards.
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        #2 rst_n = 1'b0;
        #1;
        check("abort_txd", tx_data, 0);
        check("abort_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_start1", tx_start, 0);
        @(posedge clk);
        #1;
        check("abort_start2", tx_start, 0);
        check("abort_busy2", busy, 0);

        do_txn("add", 8'h05, 8'h03, 8'h20, 8'h08, 1'b0, 1'b0);
        do_txn("sub", 8'h03, 8'h05, 8'h22, 8'hFE, 1'b1, 1'b0);
        do_txn("or_trunc", 8'hF0, 8'h0F, 8'hE5, 8'hFF, 1'b0, 1'b0);
        do_txn("unk_add", 8'h10, 8'h22, 8'h3F, 8'h32, 1'b0, 1'b0);
        do_txn("busy_drop", 8'h11, 8'h22, 8'h20, 8'h33, 1'b0, 1'b1);
        do_txn("after_drop", 8'h01, 8'h01, 8'h20, 8'h02, 1'b0, 1'b0);
        do_txn("sra", 8'h81, 8'h00, 8'h03, 8'hC0, 1'b0, 1'b0);
        do_txn("srl", 8'h81, 8'h00, 8'h02, 8'h40, 1'b0, 1'b0);
        do_txn("add_carry", 8'hFF, 8'h02, 8'h20, 8'h01, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
- Sequencing stage between a UART byte receiver/transmitter pair and the 8-bit ALU.
- Collects three received bytes in order (operand A, operand B, opcode) and presents them to the ALU as registered operands.
- Waits one settle cycle, captures the ALU result, and hands it to the UART transmitter with a start/done handshake.
- Replaces the push-button/switch operand loading with a serial front end.

Parameters:
- BUS_SIZE, 8, width of operands, result and UART bytes.
- OPCODE_SIZE, 6, width of ALU opcode; taken from the low OPCODE_SIZE bits of the third byte.

Ports:
- i_clock  input  1  system clock; all state changes on the rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_rx_data  input  BUS_SIZE  received byte; valid only while i_rx_done=1.
- i_rx_done  input  1  one-cycle pulse, byte available.
- i_alu_result  input  BUS_SIZE  ALU combinational result.
- i_alu_carry  input  1  ALU carry out.
- i_tx_done  input  1  one-cycle pulse, transmitter finished the current byte.
- o_datoA  output  BUS_SIZE  registered operand A to ALU.
- o_datoB  output  BUS_SIZE  registered operand B to ALU.
- o_opcode  output  OPCODE_SIZE  registered opcode to ALU.
- o_tx_data  output  BUS_SIZE  byte to transmit; held stable from o_tx_start until i_tx_done.
- o_tx_start  output  1  one-cycle pulse requesting transmission.
- o_busy  output  1  high from the cycle after byte 3 is accepted until the final i_tx_done is seen.

Behaviour:
- Reset (i_reset_n=0, asynchronous): state=RX_A; o_datoA, o_datoB, o_opcode, o_tx_data = 0; o_tx_start=0; o_busy=0. Reset mid-transaction aborts it; no partial byte is sent afterwards.
- States: RX_A, RX_B, RX_OP, EXEC, SEND, WAIT_TX (plus SEND_C and WAIT_TXC with the optional feature).
- RX_A: on i_rx_done, o_datoA<=i_rx_data, go to RX_B.
- RX_B: on i_rx_done, o_datoB<=i_rx_data, go to RX_OP.
- RX_OP: on i_rx_done, o_opcode<=i_rx_data[OPCODE_SIZE-1:0], go to EXEC. Upper bits are discarded. Unknown opcodes are passed through; the ALU applies its default (ADD).
- EXEC: one cycle so ALU inputs settle. o_tx_data<=i_alu_result and carry is latched internally; go to SEND.
- SEND: o_tx_start=1 for exactly this cycle; go to WAIT_TX.
- WAIT_TX: hold o_tx_data. On i_tx_done, return to RX_A, or go to SEND_C with the optional feature.
- o_busy=1 in EXEC, SEND, WAIT_TX, SEND_C and WAIT_TXC; 0 otherwise.
- Latency: o_tx_start asserts exactly 2 cycles after the cycle where the opcode byte's i_rx_done is sampled.
- i_rx_done while busy: the byte is ignored; operands are unchanged and no queuing occurs.
- i_tx_done outside the WAIT states: ignored.
- i_rx_done and i_tx_done in the same cycle in WAIT_TX: the tx_done transition is taken, and the rx byte is dropped (machine was busy in that cycle).
- Operand registers keep their values after a transaction, until overwritten by the next sequence.

Optional Feature:
- Macro: ALU_SEQ_CARRY_BYTE_EN.
- Defined: after the result byte's i_tx_done, go to SEND_C.
  - SEND_C: o_tx_data<={BUS_SIZE-1 zeros, latched carry}, pulse o_tx_start, go to WAIT_TXC.
  - WAIT_TXC: on i_tx_done go to RX_A.
  - Two bytes are sent per transaction.
- Not defined: one result byte per transaction; the carry is not transmitted, and SEND_C/WAIT_TXC do not exist.

Test Plan:
- Reset mid-stream: send 0x05, then assert i_reset_n=0 -> all outputs 0, state RX_A. Then send 0x03, 0x04, 0x20 -> o_tx_data=0x07.
- ADD: rx 0x05, 0x03, 0x20 -> o_tx_start exactly 2 cycles after third rx_done, o_tx_data=0x08, o_busy high until i_tx_done.
- SUB with borrow: rx 0x03, 0x05, 0x22 -> o_tx_data=0xFE. With ALU_SEQ_CARRY_BYTE_EN, a second byte 0x01 follows after i_tx_done.
- Opcode truncation / unknown: rx 0xF0, 0x0F, 0xE5 (low 6 bits 0x25=OR) -> o_opcode=0x25, o_tx_data=0xFF. Rx opcode 0x3F -> default ADD result.
- Busy drop: during WAIT_TX inject rx_done 0xAA, including in the same cycle as i_tx_done -> o_datoA unchanged, next sequence 0x01, 0x01, 0x20 yields 0x02.
- Shift: rx 0x81, 0x00, 0x03 -> o_tx_data=0xC0 (SRA). Opcode 0x02 -> 0x40 (SRL).
